pwm_generator: RTL and testbench

- Downstream stage of the focus PID controller.
- Consumes its 8-bit duty word and drives the single-bit PWM line to the focus actuator driver.
- Double-buffers duty updates so they apply only at period boundaries, slew-limits changes between periods, and falls back to a safe midpoint duty if the controller stops updating.
- Runs on the same 5 MHz slow clock as the controller.

---
 rtl/pwm_generator.sv | 194 +++++++++++++++++++
 tb/tb_pwm_generator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_generator
//  Description : Focus-actuator PWM stage. Takes the 8-bit duty word from the
//                PID controller and double-buffers it so that it only takes
//                effect at period boundaries. The duty actually applied is
//                slew-limited from one period to the next. If the controller
//                stops updating, the target falls back to a safe midpoint duty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_generator #(
    parameter int unsigned PERIOD_DIV   = 20,   // clk cycles per PWM phase step
    parameter int unsigned SLEW_STEP    = 4,    // max duty change per period
    parameter int unsigned WDOG_PERIODS = 16,   // silent boundaries before fallback
    parameter int unsigned SAFE_DUTY    = 128   // fallback and reset duty
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       pwm_pin,
    output logic       period_start,
    output logic [7:0] duty_applied,
    output logic       wdog_tripped
);

    // ------------------------------------------------------------------------
    // Widths and constants
    // ------------------------------------------------------------------------
    localparam int unsigned PS_W  = (PERIOD_DIV > 1) ? $clog2(PERIOD_DIV) : 1;
    // The watchdog count saturates at WDOG_PERIODS, so it must be able to hold that value
    localparam int unsigned CNT_W = $clog2(WDOG_PERIODS + 1);

    localparam logic [PS_W-1:0]  c_ps_last  = PS_W'(PERIOD_DIV - 1);
    localparam logic [CNT_W-1:0] c_cnt_sat  = CNT_W'(WDOG_PERIODS);
    localparam logic [CNT_W-1:0] c_cnt_trip = CNT_W'(WDOG_PERIODS - 1);
    localparam logic [7:0]       c_safe     = 8'(SAFE_DUTY);
    localparam logic [8:0]       c_slew     = 9'(SLEW_STEP);
    localparam logic [7:0]       c_phase_end = 8'hFF;

    // ------------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------------
    logic [PS_W-1:0]  prescaler_q, prescaler_d;
    logic [7:0]       phase_q,     phase_d;
    logic [7:0]       shadow_q,    shadow_d;
    logic             pending_q,   pending_d;
    logic [7:0]       target_q,    target_d;
    logic [7:0]       applied_q,   applied_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic             wdog_q,      wdog_d;
    logic             pwm_q,       pwm_d;
    logic             pstart_q,    pstart_d;

    // ------------------------------------------------------------------------
    // Combinational event decode
    // ------------------------------------------------------------------------
    logic       tick;
    logic       boundary;
    logic       capture;
    logic       wdog_fire;
    logic [7:0] target_new;
    logic [8:0] diff;
    logic [8:0] diff_mag;
    logic [7:0] slewed;

    // Timing events: phase step, end of period, and duty capture
    always_comb begin
        tick     = enable && (prescaler_q == c_ps_last);
        boundary = tick && (phase_q == c_phase_end);
        capture  = enable && duty_valid;
    end

    // Target chosen at the boundary: a pending update wins; otherwise the
    // watchdog may force the safe duty when this is the Nth silent boundary.
    always_comb begin
        wdog_fire  = !pending_q && (count_q == c_cnt_trip);
        target_new = target_q;
        if (pending_q) begin
            target_new = shadow_q;
        end else if (wdog_fire) begin
            target_new = c_safe;
        end
    end

    // Slew limiter: 9-bit signed difference; move by at most c_slew toward
    // the new target and land on it exactly when within reach.
    always_comb begin
        diff     = {1'b0, target_new} - {1'b0, applied_q};
        diff_mag = diff[8] ? (~diff + 9'd1) : diff;
        slewed   = target_new;
        if (diff_mag > c_slew) begin
            if (diff[8]) begin
                slewed = applied_q - c_slew[7:0];
            end else begin
                slewed = applied_q + c_slew[7:0];
            end
        end
    end

    // Prescaler and phase counters; both parked at zero while disabled
    always_comb begin
        prescaler_d = prescaler_q;
        phase_d     = phase_q;
        if (!enable) begin
            prescaler_d = '0;
            phase_d     = '0;
        end else if (tick) begin
            prescaler_d = '0;
            phase_d     = phase_q + 8'd1;
        end else begin
            prescaler_d = prescaler_q + PS_W'(1);
        end
    end

    // Shadow capture and pending flag; a capture on the boundary edge
    // survives so it is applied at the following boundary.
    always_comb begin
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (capture) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end
    end

    // Boundary update of watchdog count, trip flag, target and applied duty
    always_comb begin
        count_d   = count_q;
        wdog_d    = wdog_q;
        target_d  = target_q;
        applied_d = applied_q;
        if (!enable) begin
            count_d = '0;
        end else if (boundary) begin
            target_d  = target_new;
            applied_d = slewed;
            if (pending_q) begin
                count_d = '0;
                wdog_d  = 1'b0;
            end else begin
                if (count_q != c_cnt_sat) begin
                    count_d = count_q + CNT_W'(1);
                end
                if (wdog_fire) begin
                    wdog_d = 1'b1;
                end
            end
        end
    end

    // Output stage next values: compare against the phase being shown now
    always_comb begin
        pwm_d    = enable && (phase_q < applied_q);
        pstart_d = boundary;
    end

    // State update with asynchronous reset to the safe operating point
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q <= '0;
            phase_q     <= '0;
            shadow_q    <= c_safe;
            pending_q   <= 1'b0;
            target_q    <= c_safe;
            applied_q   <= c_safe;
            count_q     <= '0;
            wdog_q      <= 1'b0;
            pwm_q       <= 1'b0;
            pstart_q    <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            target_q    <= target_d;
            applied_q   <= applied_d;
            count_q     <= count_d;
            wdog_q      <= wdog_d;
            pwm_q       <= pwm_d;
            pstart_q    <= pstart_d;
        end
    end

    assign pwm_pin      = pwm_q;
    assign period_start = pstart_q;
    assign duty_applied = applied_q;
    assign wdog_tripped = wdog_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_generator
//  Description : Directed self-checking bench for pwm_generator with
//                PERIOD_DIV=2, SLEW_STEP=4, WDOG_PERIODS=4, SAFE_DUTY=128
//                (period = 512 clks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       pwm_pin;
    logic       period_start;
    logic [7:0] duty_applied;
    logic       wdog_tripped;

    int errors = 0;
    int checks = 0;

    pwm_generator #(
        .PERIOD_DIV   (2),
        .SLEW_STEP    (4),
        .WDOG_PERIODS (4),
        .SAFE_DUTY    (128)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .pwm_pin      (pwm_pin),
        .period_start (period_start),
        .duty_applied (duty_applied),
        .wdog_tripped (wdog_tripped)
    );

    always #5 clk = ~clk;

    // Single comparison point: count it, report a mismatch
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clk and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    // Advance to the next period_start pulse, returning the clks taken
    task automatic wait_boundary(output int n);
        int cnt;
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!period_start && cnt < 600);
        if (!period_start) check_eq("boundary_timeout", 32'd0, 32'd1);
        n = cnt;
    endtask

    task automatic next_boundary();
        int n;
        wait_boundary(n);
    endtask

    // One-clk duty strobe
    task automatic strobe(input logic [7:0] v);
        duty_in    = v;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
    endtask

    // Strobe mid-period then move to the next boundary
    task automatic strobe_mid(input logic [7:0] v);
        step_n(100);
        strobe(v);
        next_boundary();
    endtask

    // Called on a period_start cycle: count pin-high clks over one period
    // and confirm the next period_start lands exactly 512 clks later.
    task automatic measure(input string tag, input int exp_high);
        int high;
        int extra;
        high  = 0;
        extra = 0;
        for (int i = 0; i < 512; i++) begin
            high += int'(pwm_pin);
            if (i > 0) extra += int'(period_start);
            step();
        end
        check_eq({tag, "_high"}, high, exp_high);
        check_eq({tag, "_extra_pstart"}, extra, 0);
        check_eq({tag, "_next_pstart"}, {31'd0, period_start}, 1);
    endtask

    initial begin
        int n;
        int highs;
        int pulses;

        reset_n    = 1'b0;
        enable     = 1'b0;
        duty_valid = 1'b0;
        duty_in    = 8'd0;
        #12;
        check_eq("rst_pwm",    {31'd0, pwm_pin},      0);
        check_eq("rst_pstart", {31'd0, period_start}, 0);
        check_eq("rst_duty",   {24'd0, duty_applied}, 128);
        check_eq("rst_wdog",   {31'd0, wdog_tripped}, 0);
        reset_n = 1'b1;
        step();

        // Free-running at the reset duty, watchdog trips on the 4th boundary
        enable = 1'b1;
        wait_boundary(n);
        check_eq("first_boundary_clks", n, 512);
        check_eq("b1_duty", {24'd0, duty_applied}, 128);
        check_eq("b1_wdog", {31'd0, wdog_tripped}, 0);
        measure("duty128", 256);
        next_boundary();
        check_eq("b3_wdog", {31'd0, wdog_tripped}, 0);
        next_boundary();
        check_eq("b4_wdog", {31'd0, wdog_tripped}, 1);
        check_eq("b4_duty", {24'd0, duty_applied}, 128);

        // Ramp to 200 with a fresh strobe every period
        strobe_mid(8'd200);
        check_eq("ramp200_first", {24'd0, duty_applied}, 132);
        check_eq("ramp200_wdog",  {31'd0, wdog_tripped}, 0);
        for (int k = 2; k <= 17; k++) strobe_mid(8'd200);
        check_eq("ramp200_17", {24'd0, duty_applied}, 196);
        strobe_mid(8'd200);
        check_eq("ramp200_18", {24'd0, duty_applied}, 200);
        measure("duty200", 400);

        // Ramp to 255 without overshoot
        for (int k = 0; k < 14; k++) strobe_mid(8'd255);
        check_eq("ramp255", {24'd0, duty_applied}, 255);
        measure("duty255", 510);

        // Settle at 96, then two strobes in one period: the last one wins
        for (int k = 0; k < 40; k++) strobe_mid(8'd96);
        check_eq("ramp96", {24'd0, duty_applied}, 96);
        step_n(100);
        strobe(8'd90);
        step_n(100);
        strobe(8'd100);
        next_boundary();
        check_eq("last_strobe_wins", {24'd0, duty_applied}, 100);

        // Settle at 40, then go silent and watch the fallback
        for (int k = 0; k < 15; k++) strobe_mid(8'd40);
        check_eq("ramp40", {24'd0, duty_applied}, 40);
        next_boundary();
        next_boundary();
        next_boundary();
        check_eq("silent3_wdog", {31'd0, wdog_tripped}, 0);
        check_eq("silent3_duty", {24'd0, duty_applied}, 40);
        next_boundary();
        check_eq("silent4_wdog", {31'd0, wdog_tripped}, 1);
        check_eq("silent4_duty", {24'd0, duty_applied}, 44);
        next_boundary();
        check_eq("silent5_duty", {24'd0, duty_applied}, 48);
        step_n(100);
        strobe(8'd60);
        next_boundary();
        check_eq("recover_wdog", {31'd0, wdog_tripped}, 0);
        check_eq("recover_duty", {24'd0, duty_applied}, 52);
        next_boundary();
        check_eq("recover_duty2", {24'd0, duty_applied}, 56);

        // Duty zero: the pin never goes high
        for (int k = 0; k < 14; k++) strobe_mid(8'd0);
        check_eq("ramp0", {24'd0, duty_applied}, 0);
        measure("duty0", 0);

        // Strobe landing on the boundary edge applies one period later
        step_n(511);
        duty_in    = 8'd70;
        duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        check_eq("coinc_pstart", {31'd0, period_start}, 1);
        check_eq("coinc_same",   {24'd0, duty_applied}, 0);
        next_boundary();
        check_eq("coinc_next",   {24'd0, duty_applied}, 4);

        // Asynchronous reset while the pin is high
        step_n(4);
        check_eq("pre_reset_pwm", {31'd0, pwm_pin}, 1);
        #3;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_eq("async_rst_pwm",  {31'd0, pwm_pin},      0);
        check_eq("async_rst_duty", {24'd0, duty_applied}, 128);
        check_eq("async_rst_pst",  {31'd0, period_start}, 0);
        #3;
        reset_n = 1'b1;
        step();
        enable = 1'b1;
        wait_boundary(n);
        check_eq("post_reset_clks", n, 512);
        strobe_mid(8'd60);
        check_eq("pre_disable_duty", {24'd0, duty_applied}, 124);

        // Disabled for 1000 clks: pin idle, strobes ignored, duty retained
        step_n(100);
        enable = 1'b0;
        highs  = 0;
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                duty_in    = 8'd250;
                duty_valid = 1'b1;
            end
            if (i == 501) duty_valid = 1'b0;
            step();
            highs  += int'(pwm_pin);
            pulses += int'(period_start);
        end
        check_eq("disabled_pwm_high", highs, 0);
        check_eq("disabled_pstart",   pulses, 0);
        check_eq("disabled_duty",     {24'd0, duty_applied}, 124);
        enable = 1'b1;
        wait_boundary(n);
        check_eq("reenable_clks", n, 512);
        check_eq("reenable_duty", {24'd0, duty_applied}, 120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit for the whole run
    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
